// File: rtl/spi_eeprom_responder_pkg.sv
// Shared opcodes and FSM state encoding for the SPI EEPROM responder.
package spi_eeprom_pkg;

   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_WRDI  = 8'h04;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, READ, WRITE, RDSR, IGNORE
   } state_t;

endpackage

// File: rtl/spi_eeprom_responder_sync_edge.sv
// 2-FF synchronizer with one extra stage for rise/fall detection.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic r_s1, r_s2, r_s3;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1 <= RST_VAL;
         r_s2 <= RST_VAL;
         r_s3 <= RST_VAL;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_q    = r_s2;
   assign o_rise = r_s2 & ~r_s3;
   assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 slave with an EEPROM command set (WREN/WRDI/RDSR/READ/WRITE)
// over an on-chip byte memory; all SPI pins are oversampled on FCLK_CLK0.
module spi_eeprom_responder
   import spi_eeprom_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int PAGE   = 16
) (
   input  logic FCLK_CLK0,
   input  logic RST,
   input  logic i_sclk,
   input  logic i_mosi,
   input  logic i_ss_n,
   output logic o_miso,
   output logic o_miso_oe,
   output logic o_wel,
   output logic o_cmd_err
);

   localparam logic [ADDR_W-1:0] PMASK = ADDR_W'(PAGE - 1);

   state_t              r_state, w_state_nx;
   logic [2:0]          r_bit_cnt;
   logic [7:0]          r_shift_in, r_miso_sr, r_rdata;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wel, r_is_write, r_wr_armed, r_cmd_err;
   logic                r_mosi_s1, r_mosi_s2;
   logic [1:0]          r_ld_pipe;
   logic [7:0]          r_mem [DEPTH];

   logic w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
   logic w_ss_n, w_ss_rise, w_ss_fall;
   logic w_byte_done;
   logic [7:0] w_byte;
   logic w_set_wel, w_clr_wel, w_cmd_err, w_ld_sts, w_ld_addr;
   logic w_rd_start, w_rd_next, w_wr_next, w_set_wr, w_set_rd, w_mem_we;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
      .i_clk (FCLK_CLK0), .i_rst (RST), .i_d (i_sclk),
      .o_q (w_unused_sclk_lvl), .o_rise (w_sclk_rise), .o_fall (w_sclk_fall)
   );

   // ss_n resets high so releasing reset never looks like a select
   spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
      .i_clk (FCLK_CLK0), .i_rst (RST), .i_d (i_ss_n),
      .o_q (w_ss_n), .o_rise (w_ss_rise), .o_fall (w_ss_fall)
   );

   assign w_byte      = {r_shift_in[6:0], r_mosi_s2};
   assign w_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7) & ~w_ss_n;
   assign w_mem_we    = w_wr_next & r_wel & ~RST;

   always_ff @(posedge FCLK_CLK0) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_set_wel  = 1'b0;
      w_clr_wel  = 1'b0;
      w_cmd_err  = 1'b0;
      w_ld_sts   = 1'b0;
      w_ld_addr  = 1'b0;
      w_rd_start = 1'b0;
      w_rd_next  = 1'b0;
      w_wr_next  = 1'b0;
      w_set_wr   = 1'b0;
      w_set_rd   = 1'b0;
      if (w_ss_rise) begin
         w_state_nx = IDLE;
         w_clr_wel  = r_wr_armed;
      end else begin
         case (r_state)
            IDLE: if (w_ss_fall) w_state_nx = CMD;
            CMD: if (w_byte_done) begin
               case (w_byte)
                  OP_WREN:  begin w_set_wel = 1'b1; w_state_nx = IGNORE; end
                  OP_WRDI:  begin w_clr_wel = 1'b1; w_state_nx = IGNORE; end
                  OP_RDSR:  begin w_ld_sts  = 1'b1; w_state_nx = RDSR;   end
                  OP_READ:  begin w_set_rd  = 1'b1; w_state_nx = ADDR;   end
                  OP_WRITE: begin w_set_wr  = 1'b1; w_state_nx = ADDR;   end
                  default:  begin w_cmd_err = 1'b1; w_state_nx = IGNORE; end
               endcase
            end
            ADDR: if (w_byte_done) begin
               w_ld_addr  = 1'b1;
               w_rd_start = ~r_is_write;
               w_state_nx = r_is_write ? WRITE : READ;
            end
            READ:  if (w_byte_done) w_rd_next = 1'b1;
            WRITE: if (w_byte_done) w_wr_next = 1'b1;
            RDSR:  if (w_byte_done) w_ld_sts  = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge FCLK_CLK0) begin
      if (RST) begin
         r_bit_cnt  <= '0;
         r_shift_in <= '0;
         r_miso_sr  <= '0;
         r_addr     <= '0;
         r_wel      <= 1'b0;
         r_is_write <= 1'b0;
         r_wr_armed <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_mosi_s1  <= 1'b0;
         r_mosi_s2  <= 1'b0;
         r_ld_pipe  <= '0;
      end else begin
         r_mosi_s1 <= i_mosi;
         r_mosi_s2 <= r_mosi_s1;
         r_cmd_err <= w_cmd_err;
         r_ld_pipe <= {r_ld_pipe[0], w_rd_start | w_rd_next};

         if (w_ss_fall || w_ss_rise) begin
            r_bit_cnt  <= '0;
            r_shift_in <= '0;
         end else if (w_sclk_rise && !w_ss_n) begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_shift_in <= w_byte;
         end

         if (w_set_wel)      r_wel <= 1'b1;
         else if (w_clr_wel) r_wel <= 1'b0;

         if (w_set_wr)      r_is_write <= 1'b1;
         else if (w_set_rd) r_is_write <= 1'b0;

         if (w_ss_rise)                     r_wr_armed <= 1'b0;
         else if (w_ld_addr && r_is_write) r_wr_armed <= 1'b1;

         // Reads wrap the whole array; writes wrap inside the current page
         if (w_ld_addr)      r_addr <= w_byte[ADDR_W-1:0];
         else if (w_rd_next) r_addr <= r_addr + ADDR_W'(1);
         else if (w_wr_next) r_addr <= (r_addr & ~PMASK) | ((r_addr + ADDR_W'(1)) & PMASK);

         // No shift on the fall that follows a byte boundary: bit 7 must stay up
         if (w_ss_fall)                                 r_miso_sr <= '0;
         else if (w_ld_sts)                             r_miso_sr <= {6'b0, r_wel, 1'b0};
         else if (r_ld_pipe[1] && r_state == READ)      r_miso_sr <= r_rdata;
         else if (w_sclk_fall && r_bit_cnt != 3'd0)     r_miso_sr <= {r_miso_sr[6:0], 1'b0};
      end
   end

   always_ff @(posedge FCLK_CLK0) begin
      if (w_mem_we) r_mem[r_addr] <= w_byte;
      r_rdata <= r_mem[r_addr];
   end

   assign o_miso    = ((r_state == READ) || (r_state == RDSR)) & r_miso_sr[7];
   assign o_miso_oe = ~w_ss_n;
   assign o_wel     = r_wel;
   assign o_cmd_err = r_cmd_err;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed bench: bit-banged SPI master driving the EEPROM responder.
module tb_spi_eeprom_responder;

   logic FCLK_CLK0 = 1'b0;
   logic RST = 1'b1;
   logic i_sclk = 1'b0, i_mosi = 1'b0, i_ss_n = 1'b1;
   logic o_miso, o_miso_oe, o_wel, o_cmd_err;
   int   n_vec = 0, n_err = 0;
   int   n_errpulse = 0, n_misohi = 0;
   int   base_err, base_hi;
   logic [7:0] rx;

   spi_eeprom_responder #(.DEPTH(256), .ADDR_W(8), .PAGE(16)) dut (
      .FCLK_CLK0 (FCLK_CLK0), .RST (RST),
      .i_sclk (i_sclk), .i_mosi (i_mosi), .i_ss_n (i_ss_n),
      .o_miso (o_miso), .o_miso_oe (o_miso_oe),
      .o_wel (o_wel), .o_cmd_err (o_cmd_err)
   );

   always #5 FCLK_CLK0 = ~FCLK_CLK0;

   always @(posedge FCLK_CLK0) begin
      if (o_cmd_err) n_errpulse++;
      if (o_miso)    n_misohi++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge FCLK_CLK0);
   endtask

   // SCLK period is 10 system clocks; MISO sampled just before each rise
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         i_mosi = tx[i];
         clk_n(5);
         r[i]   = o_miso;
         i_sclk = 1'b1;
         clk_n(5);
         i_sclk = 1'b0;
      end
   endtask

   task automatic cs_lo();
      i_ss_n = 1'b0;
      clk_n(6);
   endtask

   task automatic cs_hi();
      clk_n(5);
      i_ss_n = 1'b1;
      clk_n(10);
   endtask

   task automatic cmd1(input logic [7:0] op);
      logic [7:0] r;
      cs_lo();
      spi_bits(op, 8, r);
      cs_hi();
   endtask

   task automatic wr_txn(input logic [7:0] a, input logic [47:0] d, input int n);
      logic [7:0] r;
      cs_lo();
      spi_bits(8'h02, 8, r);
      spi_bits(a, 8, r);
      for (int k = 0; k < n; k++) spi_bits(d[8*(n-1-k) +: 8], 8, r);
      cs_hi();
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [47:0] exp, input int n);
      logic [7:0] r;
      cs_lo();
      spi_bits(8'h03, 8, r);
      spi_bits(a, 8, r);
      for (int k = 0; k < n; k++) begin
         spi_bits(8'h00, 8, r);
         chk($sformatf("%s[%0d]", tag, k), r, exp[8*(n-1-k) +: 8]);
      end
      cs_hi();
   endtask

   task automatic rdsr_chk(input string tag, input logic [7:0] exp);
      logic [7:0] r;
      cs_lo();
      spi_bits(8'h05, 8, r);
      spi_bits(8'h00, 8, r);
      chk(tag, r, exp);
      cs_hi();
   endtask

   initial begin
      clk_n(5);
      chk("rst_miso", {7'b0, o_miso}, 8'h00);
      chk("rst_oe", {7'b0, o_miso_oe}, 8'h00);
      chk("rst_wel", {7'b0, o_wel}, 8'h00);
      chk("rst_cmd_err", {7'b0, o_cmd_err}, 8'h00);
      RST = 1'b0;
      clk_n(5);

      // WREN, then status twice in one selection
      cs_lo();
      chk("oe_selected", {7'b0, o_miso_oe}, 8'h01);
      spi_bits(8'h06, 8, rx);
      cs_hi();
      chk("wel_after_wren", {7'b0, o_wel}, 8'h01);
      cs_lo();
      spi_bits(8'h05, 8, rx);
      spi_bits(8'h00, 8, rx);
      chk("rdsr_wren", rx, 8'h02);
      spi_bits(8'h00, 8, rx);
      chk("rdsr_repeat", rx, 8'h02);
      cs_hi();
      chk("oe_deselected", {7'b0, o_miso_oe}, 8'h00);

      // Loopback write/read
      wr_txn(8'h04, 48'haaff0055c33c, 6);
      chk("wel_after_write", {7'b0, o_wel}, 8'h00);
      rdsr_chk("rdsr_after_write", 8'h00);
      rd_chk("loop", 8'h04, 48'haaff0055c33c, 6);

      // WEL gating
      cmd1(8'h06);
      wr_txn(8'h10, 48'h00, 1);
      wr_txn(8'h10, 48'h77, 1);
      chk("wel_no_wren", {7'b0, o_wel}, 8'h00);
      rd_chk("gate", 8'h10, 48'h00, 1);

      // WRDI
      cmd1(8'h06);
      chk("wel_set_again", {7'b0, o_wel}, 8'h01);
      cmd1(8'h04);
      chk("wel_after_wrdi", {7'b0, o_wel}, 8'h00);
      rdsr_chk("rdsr_after_wrdi", 8'h00);

      // Page wrap on write, array wrap on read
      cmd1(8'h06);
      wr_txn(8'h0e, 48'h11223344, 4);
      rd_chk("pwrap_hi", 8'h0e, 48'h1122, 2);
      rd_chk("pwrap_lo", 8'h00, 48'h3344, 2);
      cmd1(8'h06);
      wr_txn(8'hff, 48'h5a, 1);
      rd_chk("rwrap", 8'hff, 48'h5a33, 2);

      // Abort mid data byte
      cmd1(8'h06);
      cs_lo();
      spi_bits(8'h02, 8, rx);
      spi_bits(8'h04, 8, rx);
      spi_bits(8'h99, 4, rx);
      cs_hi();
      chk("wel_after_abort", {7'b0, o_wel}, 8'h00);
      rd_chk("abort", 8'h04, 48'haa, 1);

      // Unknown opcode
      base_err = n_errpulse;
      base_hi  = n_misohi;
      cs_lo();
      spi_bits(8'hab, 8, rx);
      spi_bits(8'h00, 8, rx);
      chk("bad_op_rx", rx, 8'h00);
      cs_hi();
      chk("cmd_err_pulses", 8'(n_errpulse - base_err), 8'd1);
      chk("bad_op_miso_hi", 8'(n_misohi - base_hi), 8'd0);

      // Reset during a READ
      cs_lo();
      spi_bits(8'h03, 8, rx);
      spi_bits(8'h04, 8, rx);
      spi_bits(8'h00, 3, rx);
      RST = 1'b1;
      clk_n(1);
      chk("rst_mid_oe", {7'b0, o_miso_oe}, 8'h00);
      chk("rst_mid_miso", {7'b0, o_miso}, 8'h00);
      i_ss_n = 1'b1;
      clk_n(3);
      RST = 1'b0;
      clk_n(5);
      chk("post_rst_oe", {7'b0, o_miso_oe}, 8'h00);
      chk("post_rst_wel", {7'b0, o_wel}, 8'h00);
      rdsr_chk("post_rst_rdsr", 8'h00);
      cmd1(8'h06);
      rdsr_chk("post_rst_wren", 8'h02);
      rd_chk("post_rst_read", 8'h04, 48'haa, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
